// File: rtl/alab_pipe_pkg.sv
// Shared pipeline definitions for the ID-stage hazard logic: register file geometry,
// the condition code that means "always", FSM states and the EXE-slot tracking record.
package alab_pipe_pkg;

  localparam int NREG   = 16;
  localparam int REG_AW = 4;

  localparam logic [3:0] COND_AL = 4'hE;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              is_load;
    logic              s;
  } exe_slot_t;

  function automatic logic [NREG-1:0] regOneHot(input logic [REG_AW-1:0] idx);
    logic [NREG-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/reg_pending_counter.sv
// Saturating up/down count of writes still in flight towards one architectural register.
module reg_pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic full_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A simultaneous issue and retire on the same register cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && dec_i && !inc_i) begin
      assert (cnt_q != '0)
        else $error("reg_pending_counter: retire with no write in flight");
    end
  end

  assign zero_o = (cnt_q == '0);
  assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage issue/stall decision: per-register pending-write scoreboard, SR pending bit,
// memory-wait freeze and branch flush for the 5-stage pipeline.
module hazard_scoreboard
  import alab_pipe_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter bit FWD_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              id_s,
  input  logic [3:0]        id_cond,
  input  logic              wb_wb_enable,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              mem_ready,
  input  logic              branch_taken,
  output logic              hazard,
  output logic              freeze_pc,
  output logic              freeze_ifid,
  output logic              flush,
  output logic              issue,
  output logic [NREG-1:0]   pending_mask
);

  pipe_state_e state_q, state_d;
  exe_slot_t   exeSlot_q, exeSlot_d;
  logic        flushPend_q, flushPend_d;

  logic [NREG-1:0] incVec, decVec, zeroVec, fullVec;

  logic srPend, srTerm, satTerm;
  logic depScoreboard, depLoadUse, depTerm;
  logic memWait;

  assign incVec = (issue && id_wb_en) ? regOneHot(id_dest) : '0;
  assign decVec = wb_wb_enable ? regOneHot(wb_dest) : '0;

  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    reg_pending_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (incVec[g]),
      .dec_i  (decVec[g]),
      .zero_o (zeroVec[g]),
      .full_o (fullVec[g])
    );
  end

  assign pending_mask = ~zeroVec;

  // Hazard looks only at registered state, so a retire in this very cycle still stalls.
  assign srPend  = exeSlot_q.valid & exeSlot_q.s;
  assign srTerm  = (id_cond != COND_AL) & srPend;
  assign satTerm = id_wb_en & fullVec[id_dest];

  assign depScoreboard = ~zeroVec[id_src1] | (id_two_src & ~zeroVec[id_src2]);
  assign depLoadUse    = exeSlot_q.valid & exeSlot_q.is_load &
                         ((id_src1 == exeSlot_q.dest) |
                          (id_two_src & (id_src2 == exeSlot_q.dest)));
  assign depTerm       = FWD_EN ? depLoadUse : depScoreboard;

  assign hazard = id_valid & (depTerm | satTerm | srTerm);

  assign memWait = (state_q == MEM_WAIT);

  // A branch seen while memory was busy is replayed on the cycle memory comes back.
  assign flush = mem_ready & (branch_taken | flushPend_q);

  assign issue = id_valid & ~hazard & ~flush & ~memWait & mem_ready;

  assign freeze_pc   = (hazard | memWait | ~mem_ready) & ~flush;
  assign freeze_ifid = freeze_pc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (!mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready)  state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    flushPend_d = mem_ready ? 1'b0 : (flushPend_q | branch_taken);
  end

  always_comb begin
    exeSlot_d = exeSlot_q;
    if (issue) begin
      exeSlot_d.valid   = 1'b1;
      exeSlot_d.dest    = id_dest;
      exeSlot_d.is_load = id_mem_read;
      exeSlot_d.s       = id_s;
    end else if (mem_ready) begin
      exeSlot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      exeSlot_q   <= '0;
      flushPend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exeSlot_q   <= exeSlot_d;
      flushPend_q <= flushPend_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of hazard_scoreboard with and without forwarding, sharing one stimulus stream.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       twoSrc;
    logic [3:0] dest;
    logic       wbEn;
    logic       memRead;
    logic       s;
    logic [3:0] cond;
  } idVec_t;

  typedef struct packed {
    logic       wbEnable;
    logic [3:0] wbDest;
    logic       memReady;
    logic       branch;
  } ctlVec_t;

  localparam logic [3:0] AL = 4'hE;
  localparam logic [3:0] EQ = 4'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid, idTwoSrc, idWbEn, idMemRead, idS;
  logic [3:0]  idSrc1, idSrc2, idDest, idCond;
  logic        wbWbEnable, memReady, branchTaken;
  logic [3:0]  wbDest;

  logic        haz0, frzPc0, frzIfid0, flush0, issue0;
  logic        haz1, frzPc1, frzIfid1, flush1, issue1;
  logic [15:0] mask0, mask1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNT_W(2), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_src1(idSrc1), .id_src2(idSrc2),
    .id_two_src(idTwoSrc), .id_dest(idDest), .id_wb_en(idWbEn), .id_mem_read(idMemRead),
    .id_s(idS), .id_cond(idCond), .wb_wb_enable(wbWbEnable), .wb_dest(wbDest),
    .mem_ready(memReady), .branch_taken(branchTaken), .hazard(haz0), .freeze_pc(frzPc0),
    .freeze_ifid(frzIfid0), .flush(flush0), .issue(issue0), .pending_mask(mask0)
  );

  hazard_scoreboard #(.CNT_W(2), .FWD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(idValid), .id_src1(idSrc1), .id_src2(idSrc2),
    .id_two_src(idTwoSrc), .id_dest(idDest), .id_wb_en(idWbEn), .id_mem_read(idMemRead),
    .id_s(idS), .id_cond(idCond), .wb_wb_enable(wbWbEnable), .wb_dest(wbDest),
    .mem_ready(memReady), .branch_taken(branchTaken), .hazard(haz1), .freeze_pc(frzPc1),
    .freeze_ifid(frzIfid1), .flush(flush1), .issue(issue1), .pending_mask(mask1)
  );

  function automatic idVec_t mkId(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                                  input logic two, input logic [3:0] d, input logic we,
                                  input logic mr, input logic sf, input logic [3:0] c);
    idVec_t r;
    r = '{valid: v, src1: s1, src2: s2, twoSrc: two, dest: d, wbEn: we,
          memRead: mr, s: sf, cond: c};
    return r;
  endfunction

  function automatic ctlVec_t mkCtl(input logic we, input logic [3:0] wd,
                                    input logic mr, input logic br);
    ctlVec_t r;
    r = '{wbEnable: we, wbDest: wd, memReady: mr, branch: br};
    return r;
  endfunction

  // Drive one cycle's inputs just after the falling edge and let the outputs settle.
  task automatic applyStimulus(input idVec_t id, input ctlVec_t ctl);
    @(negedge clk);
    idValid     = id.valid;
    idSrc1      = id.src1;
    idSrc2      = id.src2;
    idTwoSrc    = id.twoSrc;
    idDest      = id.dest;
    idWbEn      = id.wbEn;
    idMemRead   = id.memRead;
    idS         = id.s;
    idCond      = id.cond;
    wbWbEnable  = ctl.wbEnable;
    wbDest      = ctl.wbDest;
    memReady    = ctl.memReady;
    branchTaken = ctl.branch;
    #1;
  endtask

  task automatic doReset(input logic memRdy);
    @(negedge clk);
    rst = 1'b0;
    idValid = 1'b0; idSrc1 = '0; idSrc2 = '0; idTwoSrc = 1'b0; idDest = '0;
    idWbEn = 1'b0; idMemRead = 1'b0; idS = 1'b0; idCond = AL;
    wbWbEnable = 1'b0; wbDest = '0;
    memReady = memRdy;
    branchTaken = ~memRdy;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Expected control bundle is {hazard, issue, freeze_pc, freeze_ifid, flush}.
  task automatic checkCtl(input string tag, input int which, input logic [4:0] expected);
    logic [4:0] observed;
    observed = (which == 0) ? {haz0, issue0, frzPc0, frzIfid0, flush0}
                            : {haz1, issue1, frzPc1, frzIfid1, flush1};
    checkOutput(tag, {11'd0, observed}, {11'd0, expected});
  endtask

  localparam logic [4:0] C_ISSUE = 5'b01000;
  localparam logic [4:0] C_STALL = 5'b10110;
  localparam logic [4:0] C_WAIT  = 5'b00110;
  localparam logic [4:0] C_FLUSH = 5'b00001;
  localparam logic [4:0] C_IDLE  = 5'b00000;

  initial begin
    idVec_t  nop, idle, subR4, addR3, movR5, movR4;
    ctlVec_t run;
    nop   = mkId(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, AL);
    idle  = mkId(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, AL);
    subR4 = mkId(1'b1, 4'd1, 4'd0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, AL);
    addR3 = mkId(1'b1, 4'd2, 4'd1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, AL);
    movR5 = mkId(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, AL);
    movR4 = mkId(1'b1, 4'd0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, AL);
    run   = mkCtl(1'b0, 4'd0, 1'b1, 1'b0);
    rst   = 1'b0;

    // Reset state
    doReset(1'b1);
    applyStimulus(nop, run);
    checkCtl("reset_ctl0", 0, C_ISSUE);
    checkCtl("reset_ctl1", 1, C_ISSUE);
    checkOutput("reset_mask0", mask0, 16'h0000);

    // RAW on R1 without forwarding: three stall cycles, released after the WB cycle
    applyStimulus(mkId(1'b1, 4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, AL), run);
    checkCtl("t1_add", 0, C_ISSUE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(subR4, (i == 2) ? mkCtl(1'b1, 4'd1, 1'b1, 1'b0) : run);
      checkCtl($sformatf("t1_stall%0d", i), 0, C_STALL);
      checkOutput($sformatf("t1_mask%0d", i), mask0, 16'h0002);
    end
    applyStimulus(subR4, run);
    checkCtl("t1_release", 0, C_ISSUE);
    checkOutput("t1_mask_clear", mask0, 16'h0000);

    // Forwarding: load-use stalls once, ALU producer not at all
    doReset(1'b1);
    applyStimulus(mkId(1'b1, 4'd0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, AL), run);
    checkCtl("t2_ldr", 1, C_ISSUE);
    applyStimulus(addR3, run);
    checkCtl("t2_loaduse", 1, C_STALL);
    checkOutput("t2_nofwd_haz", {15'd0, haz0}, 16'h0001);
    applyStimulus(addR3, run);
    checkCtl("t2_loaduse_rel", 1, C_ISSUE);
    applyStimulus(mkId(1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, AL), run);
    checkCtl("t2_alu_fwd", 1, C_ISSUE);
    checkOutput("t2_mask1", mask1, 16'h000C);

    // SR dependency: conditional after CMP stalls once, AL does not
    doReset(1'b1);
    applyStimulus(mkId(1'b1, 4'd1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, AL), run);
    checkCtl("t3_cmp", 0, C_ISSUE);
    applyStimulus(mkId(1'b1, 4'd6, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, EQ), run);
    checkCtl("t3_moveq0", 0, C_STALL);
    checkCtl("t3_moveq1", 1, C_STALL);
    applyStimulus(mkId(1'b1, 4'd6, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, EQ), run);
    checkCtl("t3_moveq_rel", 0, C_ISSUE);
    applyStimulus(mkId(1'b1, 4'd1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, AL), run);
    checkCtl("t3_cmp2", 1, C_ISSUE);
    applyStimulus(mkId(1'b1, 4'd7, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, AL), run);
    checkCtl("t3_moval0", 0, C_ISSUE);
    checkCtl("t3_moval1", 1, C_ISSUE);

    // Memory wait with a branch arriving mid-wait
    doReset(1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(nop, mkCtl(1'b0, 4'd0, 1'b0, (i == 1)));
      checkCtl($sformatf("t4_wait%0d", i), 0, C_WAIT);
    end
    applyStimulus(nop, run);
    checkCtl("t4_flush0", 0, C_FLUSH);
    checkCtl("t4_flush1", 1, C_FLUSH);
    applyStimulus(nop, run);
    checkCtl("t4_resume", 0, C_ISSUE);

    // Same-cycle issue and retire on R5, then counter saturation on R4
    doReset(1'b1);
    applyStimulus(movR5, run);
    checkCtl("t5_mov1", 0, C_ISSUE);
    applyStimulus(movR5, mkCtl(1'b1, 4'd5, 1'b1, 1'b0));
    checkCtl("t5_mov2", 0, C_ISSUE);
    applyStimulus(idle, run);
    checkCtl("t5_idle", 0, C_IDLE);
    checkOutput("t5_mask0", mask0, 16'h0020);
    checkOutput("t5_mask1", mask1, 16'h0020);
    applyStimulus(idle, mkCtl(1'b1, 4'd5, 1'b1, 1'b0));
    applyStimulus(idle, run);
    checkOutput("t5_mask_clear", mask0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(movR4, run);
      checkCtl($sformatf("t5_fill%0d", i), 1, C_ISSUE);
    end
    applyStimulus(movR4, run);
    checkCtl("t5_sat0", 0, C_STALL);
    checkCtl("t5_sat1", 1, C_STALL);
    checkOutput("t5_sat_mask", mask0, 16'h0010);

    // Reset while waiting on memory with a flush pending and three writes in flight
    applyStimulus(movR4, mkCtl(1'b0, 4'd0, 1'b0, 1'b1));
    checkCtl("t6_wait_enter", 0, C_STALL);
    applyStimulus(nop, mkCtl(1'b0, 4'd0, 1'b0, 1'b0));
    checkCtl("t6_wait", 0, C_WAIT);
    doReset(1'b0);
    applyStimulus(nop, run);
    checkCtl("t6_post_reset0", 0, C_ISSUE);
    checkCtl("t6_post_reset1", 1, C_ISSUE);
    checkOutput("t6_mask0", mask0, 16'h0000);
    checkOutput("t6_mask1", mask1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
